// File: rtl/ula_issuer.sv
// ula_issuer: command FIFO plus issue FSM driving the ULA, one op at a time.
// Ports: cmd_* (push, valid/ready), ula_* (ULA drive and result), rsp_* (response
// valid/ready), busy, ops_done. Optional timeout: define ULA_ISSUER_TIMEOUT_EN.
module ula_issuer #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic             clk_ula,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_a,
  input  logic [15:0]      cmd_b,
  input  logic [1:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [15:0]      ula_A,
  output logic [15:0]      ula_B,
  output logic [1:0]       ula_instru,
  output logic             ula_valid,
  input  logic [31:0]      ula_data_out,
  input  logic             ula_valid_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy,
  output logic [15:0]      ops_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [15:0]      a;
    logic [15:0]      b;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP
  } state_t;

  cmd_t            fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            cmd_ready_q, cmd_ready_d;
  state_t          state_q, state_d;
  cmd_t            op_q, op_d;
  logic            ula_valid_q, ula_valid_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [15:0]     ops_done_q, ops_done_d;
  logic            push, pop;
`ifdef ULA_ISSUER_TIMEOUT_EN
  logic [7:0]      wcnt_q, wcnt_d;
  logic            rsp_err_q, rsp_err_d;
`endif

  assign push = cmd_valid && cmd_ready_q;

  always_comb begin
    pop         = 1'b0;
    state_d     = state_q;
    op_d        = op_q;
    ula_valid_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    ops_done_d  = ops_done_q;
`ifdef ULA_ISSUER_TIMEOUT_EN
    wcnt_d      = wcnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          op_d        = fifo_q[rd_ptr_q];
          ula_valid_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // op 00 answers combinationally within the issue cycle
        if (ula_valid_out) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = ula_data_out;
          rsp_tag_d   = op_q.tag;
`ifdef ULA_ISSUER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = S_RESP;
        end else begin
`ifdef ULA_ISSUER_TIMEOUT_EN
          wcnt_d      = '0;
`endif
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ula_valid_out) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = ula_data_out;
          rsp_tag_d   = op_q.tag;
`ifdef ULA_ISSUER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
          state_d     = S_RESP;
        end
`ifdef ULA_ISSUER_TIMEOUT_EN
        else if (wcnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_tag_d   = op_q.tag;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          wcnt_d      = wcnt_q + 8'd1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + 16'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    // registered so it stays low while in reset
    cmd_ready_d = (count_d != CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk_ula) begin
    if (push) fifo_q[wr_ptr_q] <= '{cmd_a, cmd_b, cmd_op, cmd_tag};
  end

  always_ff @(posedge clk_ula or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b0;
      state_q     <= S_IDLE;
      op_q        <= '0;
      ula_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      ops_done_q  <= '0;
`ifdef ULA_ISSUER_TIMEOUT_EN
      wcnt_q      <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      state_q     <= state_d;
      op_q        <= op_d;
      ula_valid_q <= ula_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      ops_done_q  <= ops_done_d;
`ifdef ULA_ISSUER_TIMEOUT_EN
      wcnt_q      <= wcnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign ula_A      = op_q.a;
  assign ula_B      = op_q.b;
  assign ula_instru = op_q.op;
  assign ula_valid  = ula_valid_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_tag    = rsp_tag_q;
  assign ops_done   = ops_done_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
`ifdef ULA_ISSUER_TIMEOUT_EN
  assign rsp_err    = rsp_err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule
